// File: rtl/nonce_search.sv
// Mining controller feeding sha256d_wrapper. It holds the header prefix, serves word requests
// with the nonce spliced in, and scans each digest for leading zeros. HASH_REVERSE_EN scans the digest last byte first.
module nonce_search #(
    parameter int NONCE_WORD = 19,
    parameter int HDR_BYTES  = 76
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_clr,
    input  logic         load_valid,
    input  logic [7:0]   load_byte,
    output logic         load_ready,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  nonce_init,
    input  logic [8:0]   target_zeros,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  nonce_out,
    output logic         s_start,
    output logic         s_rdy,
    output logic [31:0]  s_data,
    input  logic [4:0]   s_addr,
    input  logic         s_rq,
    input  logic [255:0] s_hash,
    input  logic         s_done
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HASH  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam int         KW      = $clog2(HDR_BYTES + 1);
    localparam logic [4:0] NW_IDX  = 5'(NONCE_WORD);

    logic [1:0]    state;
    logic [31:0]   hdr [NONCE_WORD];
    logic [KW-1:0] k;
    logic          hdr_full;
    logic [31:0]   nonce;
    logic [8:0]    target;
    logic          rq_prev, rq_edge;
    logic [4:0]    addr_q;
    logic [255:0]  scan;
    logic [8:0]    zcnt;
    logic [4:0]    j;
    logic          abort_lat;

    logic [31:0]   word_sel;
    logic [7:0]    cur_byte;
    logic [3:0]    lz;
    logic [8:0]    zsum;
    logic          pass, scan_end, load_take;

    assign load_ready = (state == S_IDLE) && !hdr_full;
    assign busy       = (state != S_IDLE);
    assign load_take  = load_valid && load_ready && !load_clr;

    // Header storage carries no reset; hdr_full gates any use of stale contents.
    always_ff @(posedge clk) begin
        if (load_take)
            hdr[k[KW-1:2]][{2'd3 - k[1:0], 3'b000} +: 8] <= load_byte;
    end

    always_comb begin
        word_sel = 32'h0;
        if (addr_q < NW_IDX)
            word_sel = hdr[addr_q];
        else if (addr_q == NW_IDX)
            word_sel = {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]};
    end

    always_comb begin
`ifdef HASH_REVERSE_EN
        cur_byte = scan[{j, 3'b000} +: 8];
`else
        cur_byte = scan[{~j, 3'b000} +: 8];
`endif
        lz = 4'd8;
        for (int b = 0; b < 8; b++)
            if (cur_byte[b]) lz = 4'(7 - b);
        zsum     = zcnt + 9'(lz);
        pass     = (zsum >= target);
        scan_end = (cur_byte != 8'h0) || pass || (j == 5'd31);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            k         <= '0;
            hdr_full  <= 1'b0;
            nonce     <= 32'h0;
            target    <= 9'h0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            nonce_out <= 32'h0;
            s_start   <= 1'b0;
            s_rdy     <= 1'b0;
            s_data    <= 32'h0;
            rq_prev   <= 1'b0;
            rq_edge   <= 1'b0;
            addr_q    <= 5'h0;
            scan      <= '0;
            zcnt      <= 9'h0;
            j         <= 5'h0;
            abort_lat <= 1'b0;
        end else begin
            s_start <= 1'b0;
            s_rdy   <= 1'b0;
            rq_prev <= s_rq;
            rq_edge <= 1'b0;
            if (rq_edge) begin
                s_rdy  <= 1'b1;
                s_data <= word_sel;
            end
            case (state)
                S_IDLE: begin
                    abort_lat <= 1'b0;
                    if (load_clr) begin
                        k        <= '0;
                        hdr_full <= 1'b0;
                    end else if (load_take) begin
                        k <= k + 1'b1;
                        if (k == KW'(HDR_BYTES - 1)) hdr_full <= 1'b1;
                    end
                    if (start && hdr_full) begin
                        nonce     <= nonce_init;
                        target    <= target_zeros;
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        s_start   <= 1'b1;
                        state     <= S_HASH;
                    end
                end
                S_HASH: begin
                    if (abort) abort_lat <= 1'b1;
                    if (s_rq && !rq_prev) begin
                        rq_edge <= 1'b1;
                        addr_q  <= s_addr;
                    end
                    if (s_done) begin
                        if (abort_lat || abort) begin
                            state <= S_IDLE;
                        end else begin
                            scan  <= s_hash;
                            zcnt  <= 9'h0;
                            j     <= 5'h0;
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (abort) abort_lat <= 1'b1;
                    if (abort_lat) begin
                        state <= S_IDLE;
                    end else begin
                        zcnt <= zsum;
                        j    <= j + 5'd1;
                        if (scan_end) begin
                            if (pass) begin
                                found     <= 1'b1;
                                nonce_out <= nonce;
                                state     <= S_IDLE;
                            end else if (nonce == 32'hFFFF_FFFF) begin
                                exhausted <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                nonce   <= nonce + 32'd1;
                                s_start <= 1'b1;
                                state   <= S_HASH;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nonce_search.sv
// Randomized bench for nonce_search: a wrapper model serves every hash, and a behavioural
// model predicts the nonce walk, the words served and the final flags.
module tb_nonce_search;
    localparam int NW = 19;
    localparam int HB = 76;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         load_clr = 0, load_valid = 0, load_ready;
    logic [7:0]   load_byte = 0;
    logic         start = 0, abort = 0, busy, found, exhausted;
    logic [31:0]  nonce_init = 0, nonce_out;
    logic [8:0]   target_zeros = 0;
    logic         s_start, s_rdy, s_rq = 0, s_done = 0;
    logic [31:0]  s_data;
    logic [4:0]   s_addr = 0;
    logic [255:0] s_hash = '0;

    nonce_search dut (
        .clk(clk), .rst_n(rst_n), .load_clr(load_clr), .load_valid(load_valid),
        .load_byte(load_byte), .load_ready(load_ready), .start(start), .abort(abort),
        .nonce_init(nonce_init), .target_zeros(target_zeros), .busy(busy), .found(found),
        .exhausted(exhausted), .nonce_out(nonce_out), .s_start(s_start), .s_rdy(s_rdy),
        .s_data(s_data), .s_addr(s_addr), .s_rq(s_rq), .s_hash(s_hash), .s_done(s_done)
    );

    always #5 clk = ~clk;

    int          tests = 0, fails = 0;
    logic [7:0]  hb [HB];
    logic [31:0] cur_nonce = 0, exp_word = 0, win_nonce = 0;
    int          lose_z = 0, win_z = 0, last_lat = 0;
    bit          win_en = 0;
    logic [31:0] cap [32];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    function automatic logic [31:0] model_word(input int a, input logic [31:0] n);
        if (a < NW) return {hb[4*a], hb[4*a+1], hb[4*a+2], hb[4*a+3]};
        if (a == NW) return bswap(n);
        return 32'h0;
    endfunction

    function automatic int lz_bits(input logic [255:0] h);
        for (int i = 255; i >= 0; i--)
            if (h[i]) return 255 - i;
        return 256;
    endfunction

    function automatic logic [255:0] byterev(input logic [255:0] h);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = h[8*(31-i) +: 8];
        return r;
    endfunction

    function automatic int scan_lz(input logic [255:0] h);
`ifdef HASH_REVERSE_EN
        return lz_bits(byterev(h));
`else
        return lz_bits(h);
`endif
    endfunction

    function automatic int zeros_for(input logic [31:0] n);
        return (win_en && n == win_nonce) ? win_z : lose_z;
    endfunction

    function automatic logic [255:0] make_hash(input int z);
        logic [255:0] h;
        for (int i = 0; i < 8; i++) h[32*i +: 32] = $urandom;
        if (z >= 256) h = '0;
        else begin
            h = h & ({256{1'b1}} >> z);
            h[255-z] = 1'b1;
        end
`ifdef HASH_REVERSE_EN
        h = byterev(h);
`endif
        return h;
    endfunction

    // Compare process: every served word and the one-cycle/hold behaviour of s_rdy/s_data.
    logic [31:0] held = 0;
    bit          held_v = 0, prev_rdy = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v   = 0;
            prev_rdy = 0;
        end else begin
            if (s_rdy) begin
                chk("s_data", s_data, exp_word);
                chk("rdy_one_cycle", prev_rdy, 0);
                held   = s_data;
                held_v = 1;
            end else if (held_v) begin
                chk("s_data_hold", s_data, held);
            end
            prev_rdy = s_rdy;
        end
    end

    task automatic load_all(input bit seq);
        for (int i = 0; i < HB; i++) hb[i] = seq ? 8'(i) : 8'($urandom);
        for (int i = 0; i < HB; ) begin
            @(negedge clk);
            chk("load_ready_hi", load_ready, 1);
            if ($urandom_range(0, 3) == 0) load_valid = 0;
            else begin
                load_valid = 1;
                load_byte  = hb[i];
                i++;
            end
        end
        @(negedge clk);
        chk("load_ready_full", load_ready, 0);
        load_valid = 1;
        load_byte  = 8'hA5;
        @(negedge clk);
        load_valid = 0;
    endtask

    task automatic clr_reload();
        @(negedge clk);
        load_clr   = 1;
        load_valid = 1;
        load_byte  = 8'hEE;
        @(negedge clk);
        load_clr   = 0;
        load_valid = 0;
        chk("load_ready_clr", load_ready, 1);
        load_all(0);
    endtask

    task automatic serve_req(input int a, input int hold);
        int w;
        exp_word = model_word(a, cur_nonce);
        s_addr   = 5'(a);
        s_rq     = 1;
        w        = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!s_rdy && w < 6);
        chk("rdy_latency", w, 2);
        cap[a] = s_data;
        repeat (hold) @(negedge clk);
        s_rq = 0;
        @(negedge clk);
    endtask

    task automatic serve_hash(input bit do_abort);
        logic [255:0] h;
        int z;
        for (int a = 0; a <= NW + 1; a++) begin
            serve_req(a, (a == 3) ? 3 : 0);
            if (do_abort && a == 10) begin
                abort = 1;
                @(negedge clk);
                abort = 0;
            end
        end
        serve_req($urandom_range(NW + 2, 31), 0);
        z = zeros_for(cur_nonce);
        h = make_hash(z);
        chk("model_lz", scan_lz(h), z);
        s_hash = h;
        s_done = 1;
        @(negedge clk);
        s_done = 0;
    endtask

    task automatic run_search(input logic [31:0] ninit, input logic [8:0] tz, input bit do_abort);
        logic [31:0] n;
        int cnt, nh, cyc, extra;
        bit ef, ee;
        n = ninit; cnt = 0; ef = 0; ee = 0;
        if (do_abort) cnt = 1;
        else begin
            while (cnt < 64) begin
                cnt++;
                if (zeros_for(n) >= int'(tz)) begin ef = 1; break; end
                if (n == 32'hFFFF_FFFF) begin ee = 1; break; end
                n++;
            end
        end
        @(negedge clk);
        nonce_init   = ninit;
        target_zeros = tz;
        start        = 1;
        @(negedge clk);
        start = 0;
        nh = 0; cyc = 0;
        while (cyc < 40 && nh <= 64) begin
            if (s_start) begin
                cur_nonce = ninit + 32'(nh);
                nh++;
                serve_hash(do_abort && nh == 1);
                cyc = 0;
                continue;
            end
            if (!busy) break;
            @(negedge clk);
            cyc++;
        end
        last_lat = cyc;
        chk("busy_bound", cyc < 40, 1);
        extra = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_start) extra++;
        end
        chk("no_extra_start", extra, 0);
        chk("hash_count", nh, cnt);
        chk("busy_end", busy, 0);
        chk("found", found, ef);
        chk("exhausted", exhausted, ee);
        if (ef) chk("nonce_out", nonce_out, n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] h;
        logic [31:0] r;
        logic [8:0] tz;

        repeat (3) @(negedge clk);
        chk("rst_outs", {s_start, s_rdy, s_data, found, exhausted, nonce_out, busy}, 0);
        chk("rst_load_ready", load_ready, 1);
        rst_n = 1;

        h = 256'h0F << 232;
        chk("pin_lz20", lz_bits(h), 20);
        h = '0;
        chk("pin_lz256", lz_bits(h), 256);
        h = 256'h1 << 255;
        chk("pin_lz0", lz_bits(h), 0);

        // Sequential header, single passing hash.
        load_all(1);
        win_en = 1; win_nonce = 32'h1234_5678; win_z = 20; lose_z = 0;
        run_search(32'h1234_5678, 9'd20, 0);
        chk("word0", cap[0], 32'h0001_0203);
        chk("word19", cap[19], 32'h7856_3412);
        chk("word20", cap[20], 32'h0);
        chk("busy_lat", last_lat <= 4, 1);
        chk("pin_nonce_out", nonce_out, 32'h1234_5678);

        // Walk 5 -> 7.
        win_nonce = 32'd7; win_z = 24; lose_z = 8;
        run_search(32'd5, 9'd20, 0);
        chk("pin_walk", nonce_out, 32'd7);

        // Exhaustion at the top of the range.
        win_en = 0; lose_z = 10;
        run_search(32'hFFFF_FFFE, 9'd20, 0);
        chk("pin_exh", {found, exhausted}, 2'b01);

        // Zero target passes immediately.
        lose_z = 0;
        run_search($urandom, 9'd0, 0);

        for (int it = 0; it < 6; it++) begin
            clr_reload();
            r  = (it % 2 == 0) ? $urandom : 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            tz = 9'($urandom_range(1, 256));
            lose_z    = $urandom_range(0, int'(tz) - 1);
            win_en    = $urandom_range(0, 3) != 0;
            win_nonce = r + 32'($urandom_range(0, 4));
            win_z     = $urandom_range(int'(tz), 256);
            run_search(r, tz, 0);
        end

        // Abort mid-hash, then a fresh load and run.
        win_en = 0; lose_z = 0;
        run_search($urandom, 9'd100, 1);
        clr_reload();
        win_en = 1; win_nonce = 32'h0000_0042; win_z = 256;
        run_search(32'h0000_0040, 9'd256, 0);

        // Asynchronous reset mid-hash.
        @(negedge clk);
        nonce_init = 32'hDEAD_BEEF; target_zeros = 9'd30; start = 1;
        @(negedge clk);
        start = 0;
        chk("pre_rst_busy", busy, 1);
        cur_nonce = 32'hDEAD_BEEF;
        serve_req(0, 0);
        #2 rst_n = 0;
        #1;
        chk("async_rst_outs", {s_start, s_rdy, s_data, found, exhausted, nonce_out, busy}, 0);
        chk("async_rst_ready", load_ready, 1);
        @(negedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        start = 1;
        repeat (3) @(negedge clk);
        chk("start_ignored", busy, 0);
        start = 0;
        load_all(0);
        win_nonce = 32'h0000_0100; win_z = 40; lose_z = 3;
        run_search(32'h0000_00FE, 9'd33, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/nonce_search.md
Name: nonce_search

Overview:
- Mining controller that sits directly upstream of sha256d_wrapper.
- Holds the 76-byte block-header prefix loaded byte-serially. Serves the wrapper's word requests, inserting the current nonce as word 19.
- After each double hash, scans the result for leading zero bits against a target. Stops with the winning nonce, or walks the nonce range until it is exhausted.

Parameters:
- NONCE_WORD, 19, header word index replaced by the byte-swapped nonce.
- HDR_BYTES, 76, number of prefix bytes accepted on the load port (must be 4*NONCE_WORD).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_clr  in  1  synchronous clear of the load byte counter and hdr_full (honoured in S_IDLE only)
- load_valid  in  1  load byte strobe
- load_byte  in  8  header byte, first byte first
- load_ready  out  1  high in S_IDLE while fewer than HDR_BYTES bytes are loaded
- start  in  1  begin search (level, sampled in S_IDLE)
- abort  in  1  request stop
- nonce_init  in  32  first nonce, latched on accepted start
- target_zeros  in  9  required leading zero bits (0..256), latched on accepted start
- busy  out  1  state != S_IDLE
- found  out  1  sticky success flag
- exhausted  out  1  sticky flag: nonce 0xFFFFFFFF tried without success
- nonce_out  out  32  winning nonce (valid when found)
- s_start  out  1  one-cycle start pulse to the wrapper
- s_rdy  out  1  one-cycle data-valid pulse to the wrapper
- s_data  out  32  requested word
- s_addr  in  5  wrapper word address
- s_rq  in  1  wrapper request (level)
- s_hash  in  256  wrapper result, MSB = first digest bit
- s_done  in  1  wrapper completion

Behaviour:
- Reset: state S_IDLE; the following are 0:
  - outputs: s_start, s_rdy, s_data, found, exhausted, nonce_out
  - internal: load counter, hdr_full
- Load (S_IDLE only):
  - Each cycle with load_valid && load_ready stores byte k into word k/4, bits [31-8*(k%4) -: 8], then increments k.
  - At k == HDR_BYTES, hdr_full=1 and load_ready=0.
  - load_valid while !load_ready is ignored.
  - load_clr has priority over load_valid in the same cycle.
- States: S_IDLE, S_HASH, S_CHECK.
- S_IDLE:
  - start && hdr_full → latch nonce_init and target_zeros; clear found and exhausted; pulse s_start next cycle; go to S_HASH.
  - start with !hdr_full is ignored.
- S_HASH request serving:
  - A rising edge of s_rq is detected against the registered previous s_rq. The edge sampled at edge N gives s_data and s_rdy=1 registered at edge N+1. s_rdy is high for exactly one cycle.
  - s_data holds its value until the next request.
  - Word selection:
    - addr < NONCE_WORD → stored word.
    - addr == NONCE_WORD → {nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24]}.
    - addr > NONCE_WORD → 32'h0.
  - A level-high s_rq without an edge produces no new pulse.
- S_HASH exit: s_done → capture s_hash into the scan register; zcnt=0, j=0; go to S_CHECK.
- S_CHECK scans one byte per cycle, j = 0..31; byte j = hash[255-8j -: 8].
  - Byte zero → zcnt += 8.
  - Byte nonzero → zcnt += leading zeros of the byte, then stop.
  - Scan ends on a nonzero byte, on zcnt >= target_zeros (early exit), or at j == 31. Maximum zcnt is 256, which needs a 9-bit counter.
- S_CHECK result:
  - pass (zcnt >= target_zeros) → found=1, nonce_out=nonce, go to S_IDLE.
  - fail and nonce == 32'hFFFFFFFF → exhausted=1, go to S_IDLE.
  - fail otherwise → nonce += 1, pulse s_start, go to S_HASH.
  - target_zeros == 0 always passes on the first nonce.
- Abort:
  - abort is latched in any non-idle state; the latch clears on entering S_IDLE.
  - In S_CHECK, or on s_done in S_HASH, a latched abort goes to S_IDLE with found and exhausted unchanged (0). No further s_start is issued.
  - Abort never cuts a wrapper transaction short.
- start held high through completion re-arms only after busy falls, because S_IDLE samples start again. Benches must deassert start before the run completes.
- The header is retained across runs, so a new start reuses it with a new nonce_init.

Optional Feature:
- Macro HASH_REVERSE_EN.
- Defined: byte j in S_CHECK = hash[8j+7 -: 8], i.e. the digest is scanned last byte first. This matches the Bitcoin little-endian target comparison.
- Undefined: scan in digest order as above.
- No port or timing change.

Test Plan:
- Load 76 bytes 0x00..0x4B, start, nonce_init=0x12345678 → on the addr=0 request s_data=0x00010203; on addr=19 s_data=0x78563412; on addr=20 s_data=0.
- Wrapper model returns hash 0x0000_0F.. with target_zeros=20 → one pass, found=1, nonce_out=nonce_init, busy falls at most 4 cycles after s_done.
- Model returns hash with 8 leading zeros for nonces 5..6 and 24 zeros for nonce 7; target 20, nonce_init=5 → three s_start pulses, nonce_out=7.
- nonce_init=0xFFFFFFFE, model never passes → two hashes, exhausted=1, found=0.
- abort asserted mid-S_HASH → the wrapper completes, no further s_start is issued, busy falls, found=0; a start after load_clr plus a new load works.
- rst_n pulsed low mid-S_HASH → all outputs 0 asynchronously, load_ready=1, start ignored until 76 bytes are reloaded.
